// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - op encodings and FSM states for the word logic/shift unit
package logic_pkg;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_SHL = 3'd4;
  localparam logic [2:0] OP_SHR = 3'd5;
  localparam logic [2:0] OP_ROL = 3'd6;
  localparam logic [2:0] OP_ASR = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/word_shift_step.sv
// rtl/word_shift_step.sv - single-bit shift/rotate step; op[1:0] selects SHL/SHR/ROL/ASR
module word_shift_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] w,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] next_w,
  output logic             carry_out
);
  always_comb begin
    next_w    = w;
    carry_out = 1'b0;
    case (op)
      2'b00: begin
        next_w    = {w[WIDTH-2:0], 1'b0};
        carry_out = w[WIDTH-1];
      end
      2'b01: begin
        next_w    = {1'b0, w[WIDTH-1:1]};
        carry_out = w[0];
      end
      2'b10: begin
        next_w    = {w[WIDTH-2:0], w[WIDTH-1]};
        carry_out = w[WIDTH-1];
      end
      default: begin
        next_w    = {w[WIDTH-1], w[WIDTH-1:1]};
        carry_out = w[0];
      end
    endcase
  end
endmodule

// File: rtl/word_logic_shift_unit.sv
// rtl/word_logic_shift_unit.sv - WIDTH-bit logic ops plus iterative shifts with valid/ready on both sides
module word_logic_shift_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               carry,
  output logic               zero,
  output logic               busy
);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t             r_state;
  state_t             w_next_state;
  logic [1:0]         r_shop;
  logic [WIDTH-1:0]   r_w;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;

  logic [WIDTH-1:0]   w_and, w_or, w_xor, w_not;
  logic [WIDTH-1:0]   w_logic_res;
  logic [WIDTH-1:0]   w_step_w;
  logic               w_step_carry;
  logic               w_shift_now;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign w_and[i] = a[i] & b[i];
    assign w_or[i]  = a[i] | b[i];
    assign w_xor[i] = a[i] ^ b[i];
    assign w_not[i] = ~a[i];
  end

  always_comb begin
    w_logic_res = w_and;
    case (op[1:0])
      2'b00:   w_logic_res = w_and;
      2'b01:   w_logic_res = w_or;
      2'b10:   w_logic_res = w_xor;
      default: w_logic_res = w_not;
    endcase
  end

  // A zero-amount shift bypasses SHIFT and delivers a unchanged with carry 0.
  assign w_shift_now = op[2] && (shamt != '0);

  word_shift_step #(.WIDTH(WIDTH)) u_step (
    .w         (r_w),
    .op        (r_shop),
    .next_w    (w_step_w),
    .carry_out (w_step_carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = w_shift_now ? SHIFT : DONE;
      SHIFT:   if (r_cnt == CNT_ONE) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // result/carry only change when a new value is delivered, so they hold through IDLE and SHIFT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shop   <= 2'b00;
      r_w      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shop <= op[1:0];
            r_w    <= a;
            r_cnt  <= shamt;
            if (!w_shift_now) begin
              r_result <= op[2] ? a : w_logic_res;
              r_carry  <= 1'b0;
            end
          end
        end
        SHIFT: begin
          r_w   <= w_step_w;
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_result <= w_step_w;
            r_carry  <= w_step_carry;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign result    = r_result;
  assign carry     = r_carry;
  assign zero      = (r_result == '0);
endmodule

// File: tb/tb_word_logic_shift_unit.sv
// tb/tb_word_logic_shift_unit.sv - randomized self-checking bench with behavioural reference model
module tb_word_logic_shift_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [2:0] op = 3'd0;
  logic [2:0] shamt = 3'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       in_ready, out_valid, carry, zero, busy;
  logic [7:0] result;

  word_logic_shift_unit #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] r;
    logic       c;
    int         acc;
    int         lat;
  } exp_t;
  exp_t q[$];
  bit         seen_front = 1'b0;
  logic [7:0] last_r = 8'd0;
  logic       last_c = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic model(input logic [2:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                       input int s, output logic [7:0] r, output logic c);
    c = 1'b0;
    case (mop)
      3'd0: r = ma & mb;
      3'd1: r = ma | mb;
      3'd2: r = ma ^ mb;
      3'd3: r = ~ma;
      3'd4: begin r = 8'(ma << s); if (s != 0) c = ma[8-s]; end
      3'd5: begin r = ma >> s;     if (s != 0) c = ma[s-1]; end
      3'd6: begin r = 8'((ma << s) | (ma >> (8 - s))); if (s != 0) c = r[0]; end
      default: begin r = 8'($signed(ma) >>> s); if (s != 0) c = ma[s-1]; end
    endcase
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_in_ready", busy, !in_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          chk("result", result, q[0].r);
          chk("carry", carry, q[0].c);
          chk("zero", zero, q[0].r == 8'd0);
          chk("in_ready_in_done", in_ready, 1'b0);
          if (!seen_front) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            if (q[0].op == 3'd6) chk("rol_popcount", $countones(result), $countones(q[0].a));
            seen_front = 1'b1;
          end
        end
      end else begin
        chk("hold_result", result, last_r);
        chk("hold_carry", carry, last_c);
        chk("hold_zero", zero, last_r == 8'd0);
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && q.size() > 0) begin
      last_r = q[0].r;
      last_c = q[0].c;
      void'(q.pop_front());
      seen_front = 1'b0;
    end
  end

  task automatic do_op(input logic [2:0] dop, input logic [7:0] da, input logic [7:0] db,
                       input int s, input int stall);
    exp_t e;
    int   n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1; op = dop; a = da; b = db; shamt = 3'(s);
    e.op = dop; e.a = da; e.acc = cyc;
    e.lat = (dop[2] && s != 0) ? 1 + s : 1;
    model(dop, da, db, s, e.r, e.c);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); shamt = 3'($urandom);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    chk("done_timeout", out_valid, 1'b1);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_to_idle", in_ready, 1'b1);
  endtask

  task automatic pin(input string name, input logic [2:0] pop, input logic [7:0] pa,
                     input logic [7:0] pb, input int s, input logic [7:0] er, input logic ec);
    logic [7:0] r;
    logic       c;
    model(pop, pa, pb, s, r, c);
    chk({"pin_", name, "_result"}, r, er);
    chk({"pin_", name, "_carry"}, c, ec);
    do_op(pop, pa, pb, s, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", result, 8'd0);
    chk("reset_carry", carry, 1'b0);
    chk("reset_zero", zero, 1'b1);
    chk("reset_busy", busy, 1'b0);

    pin("and",   3'd0, 8'hF0, 8'h3C, 0, 8'h30, 1'b0);
    pin("xor",   3'd2, 8'h5A, 8'h5A, 0, 8'h00, 1'b0);
    pin("not",   3'd3, 8'h0F, 8'h00, 0, 8'hF0, 1'b0);
    pin("shl1",  3'd4, 8'h81, 8'h00, 1, 8'h02, 1'b1);
    pin("rol3",  3'd6, 8'h81, 8'h00, 3, 8'h0C, 1'b0);
    pin("asr7",  3'd7, 8'h80, 8'h00, 7, 8'hFF, 1'b0);
    pin("shr7",  3'd5, 8'h80, 8'h00, 7, 8'h01, 1'b0);
    pin("shl0",  3'd4, 8'hA5, 8'h00, 0, 8'hA5, 1'b0);
    pin("shl7",  3'd4, 8'hFF, 8'h00, 7, 8'h80, 1'b1);

    do_op(3'd1, 8'h12, 8'h40, 0, 10);
    do_op(3'd7, 8'hC3, 8'h00, 5, 10);

    @(negedge clk);
    in_valid = 1'b1; op = 3'd6; a = 8'hB7; shamt = 3'd5;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_result", result, 8'd0);
    chk("midrst_zero", zero, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    last_r = 8'd0;
    last_c = 1'b0;
    q.delete();
    seen_front = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(3'd6, 8'hB7, 8'h00, 5, 0);

    for (int i = 0; i < 300; i++) begin
      do_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
